// File: rtl/addr_readback.sv
// addr_readback: registered read-back of the blitter A1/A2 x/y address halves
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   rd_req_i       single-cycle read request, no back-pressure
//   rd_sel_i       0 A1 pixel, 1 A1 fraction, 2 A2 pixel, 3 reserved (zero)
//   narrow_i       1 = 16-bit CPU access, 0 = 32-bit GPU access
//   hiword_i       narrow only: 1 = y half, 0 = x half
//   a1_*/a2_*_i    live address halves
//   dout_o         read data, x on [0:15], y on [16:31]
//   dout_valid_o   one-cycle data strobe
//   hold_valid_o   a narrow snapshot is pending
// Optional macro ADDR_RDBK_TIMEOUT_EN expires a snapshot after HOLD_TIMEOUT cycles.
module addr_readback #(
   parameter int HOLD_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rd_req_i,
   input  logic [0:1]  rd_sel_i,
   input  logic        narrow_i,
   input  logic        hiword_i,
   input  logic [0:15] a1_x_i,
   input  logic [0:15] a1_y_i,
   input  logic [0:15] a1_fx_i,
   input  logic [0:15] a1_fy_i,
   input  logic [0:15] a2_x_i,
   input  logic [0:15] a2_y_i,
   output logic [0:31] dout_o,
   output logic        dout_valid_o,
   output logic        hold_valid_o
);
   typedef enum logic {IDLE, HELD} state_t;
   if (HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > 65535) begin : g_bad_timeout
      $error("HOLD_TIMEOUT out of range");
   end
   state_t      state_q, state_d;
   logic [0:31] dout_q, dout_d;
   logic        valid_q, valid_d;
   logic [0:15] hold_y_q, hold_y_d;
   logic [0:1]  tag_q, tag_d;
   logic [0:15] sel_x, sel_y;
   logic        timeout;
   assign sel_x = rd_sel_i == 2'd0 ? a1_x_i : rd_sel_i == 2'd1 ? a1_fx_i :
                  rd_sel_i == 2'd2 ? a2_x_i : 16'h0;
   assign sel_y = rd_sel_i == 2'd0 ? a1_y_i : rd_sel_i == 2'd1 ? a1_fy_i :
                  rd_sel_i == 2'd2 ? a2_y_i : 16'h0;
`ifdef ADDR_RDBK_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   assign timeout = state_q == HELD && cnt_q == 16'(HOLD_TIMEOUT);
   // counter restarts on every fresh snapshot, runs only while HELD
   assign cnt_d = rd_req_i && narrow_i && !hiword_i ? 16'h0 :
                  state_q == HELD ? cnt_q + 16'h1 : cnt_q;
   always_ff @(posedge clk_i) cnt_q <= reset_i ? 16'h0 : cnt_d;
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d  = timeout ? IDLE : state_q;
      dout_d   = dout_q;
      valid_d  = rd_req_i;
      hold_y_d = hold_y_q;
      tag_d    = tag_q;
      if (rd_req_i) begin
         if (!narrow_i) begin
            dout_d  = {sel_x, sel_y};
            state_d = IDLE;
         end else if (!hiword_i) begin
            dout_d   = {sel_x, 16'h0};
            hold_y_d = sel_y;
            tag_d    = rd_sel_i;
            state_d  = HELD;
         end else begin
            // a high read in the timeout cycle still sees the snapshot
            dout_d  = {16'h0, state_q == HELD && tag_q == rd_sel_i ? hold_y_q : sel_y};
            state_d = IDLE;
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         hold_y_q <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         hold_y_q <= hold_y_d;
         tag_q    <= tag_d;
      end
   end
   assign dout_o       = dout_q;
   assign dout_valid_o = valid_q;
   assign hold_valid_o = state_q == HELD;
endmodule

// File: tb/tb_addr_readback.sv
// tb_addr_readback: directed self-checking bench for addr_readback
module tb_addr_readback;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd_req = 1'b0;
   logic [0:1]  rd_sel = 2'd0;
   logic        narrow = 1'b0;
   logic        hiword = 1'b0;
   logic [0:15] a1_x = 16'h0, a1_y = 16'h0, a1_fx = 16'h0, a1_fy = 16'h0;
   logic [0:15] a2_x = 16'h0, a2_y = 16'h0;
   logic [0:31] dout;
   logic        dout_valid, hold_valid;
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   addr_readback #(.HOLD_TIMEOUT(4)) dut (
      .clk_i(clk), .reset_i(reset), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
      .narrow_i(narrow), .hiword_i(hiword),
      .a1_x_i(a1_x), .a1_y_i(a1_y), .a1_fx_i(a1_fx), .a1_fy_i(a1_fy),
      .a2_x_i(a2_x), .a2_y_i(a2_y),
      .dout_o(dout), .dout_valid_o(dout_valid), .hold_valid_o(hold_valid)
   );
   task automatic req(input logic n, input logic h, input logic [0:1] s);
      @(negedge clk);
      rd_req = 1'b1;
      narrow = n;
      hiword = h;
      rd_sel = s;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask
   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (dout !== 32'h0 || dout_valid !== 1'b0 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset: dout=%h valid=%b hold=%b, want 0/0/0", dout, dout_valid, hold_valid);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic test_wide;
      a2_x = 16'h1234;
      a2_y = 16'hABCD;
      req(1'b0, 1'b0, 2'd2);
      checks++;
      if (dout !== 32'h1234ABCD || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL wide: dout=%h valid=%b, want 1234abcd/1", dout, dout_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dout_valid !== 1'b0 || dout !== 32'h1234ABCD) begin
         errors++;
         $display("FAIL wide_idle: dout=%h valid=%b, want 1234abcd/0", dout, dout_valid);
      end
   endtask
   task automatic test_narrow_pair;
      a1_x = 16'h0010;
      a1_y = 16'h0020;
      req(1'b1, 1'b0, 2'd0);
      checks++;
      if (dout !== 32'h00100000 || dout_valid !== 1'b1 || hold_valid !== 1'b1) begin
         errors++;
         $display("FAIL narrow_lo: dout=%h valid=%b hold=%b, want 00100000/1/1", dout, dout_valid, hold_valid);
      end
      a1_y = 16'h0099;
      req(1'b1, 1'b1, 2'd0);
      checks++;
      if (dout !== 32'h00000020 || dout_valid !== 1'b1 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL narrow_hi: dout=%h valid=%b hold=%b, want 00000020/1/0", dout, dout_valid, hold_valid);
      end
   endtask
   task automatic test_stale_tag;
      req(1'b1, 1'b0, 2'd0);
      checks++;
      if (hold_valid !== 1'b1) begin
         errors++;
         $display("FAIL stale_lo: hold=%b, want 1", hold_valid);
      end
      a2_y = 16'h0777;
      req(1'b1, 1'b1, 2'd2);
      checks++;
      if (dout !== 32'h00000777 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL stale_hi: dout=%h hold=%b, want 00000777/0", dout, hold_valid);
      end
   endtask
   task automatic test_hi_idle;
      a1_fy = 16'h6666;
      req(1'b1, 1'b1, 2'd1);
      checks++;
      if (dout !== 32'h00006666 || dout_valid !== 1'b1 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL hi_idle: dout=%h valid=%b hold=%b, want 00006666/1/0", dout, dout_valid, hold_valid);
      end
   endtask
   task automatic test_back_to_back;
      a1_fx = 16'h5555;
      req(1'b0, 1'b0, 2'd0);
      checks++;
      if (dout !== 32'h00100099 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_0: dout=%h valid=%b, want 00100099/1", dout, dout_valid);
      end
      req(1'b0, 1'b0, 2'd1);
      checks++;
      if (dout !== 32'h55556666 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_1: dout=%h valid=%b, want 55556666/1", dout, dout_valid);
      end
      req(1'b0, 1'b0, 2'd3);
      checks++;
      if (dout !== 32'h00000000 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_3: dout=%h valid=%b, want 00000000/1", dout, dout_valid);
      end
   endtask
   task automatic test_sel3_narrow;
      req(1'b0, 1'b0, 2'd2);
      req(1'b1, 1'b0, 2'd3);
      checks++;
      if (dout !== 32'h0 || dout_valid !== 1'b1 || hold_valid !== 1'b1) begin
         errors++;
         $display("FAIL sel3_lo: dout=%h valid=%b hold=%b, want 0/1/1", dout, dout_valid, hold_valid);
      end
      req(1'b1, 1'b1, 2'd3);
      checks++;
      if (dout !== 32'h0 || dout_valid !== 1'b1 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL sel3_hi: dout=%h valid=%b hold=%b, want 0/1/0", dout, dout_valid, hold_valid);
      end
   endtask
   task automatic test_reset_in_req;
      req(1'b1, 1'b0, 2'd2);
      checks++;
      if (dout !== 32'h12340000 || hold_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: dout=%h hold=%b, want 12340000/1", dout, hold_valid);
      end
      @(negedge clk);
      reset = 1'b1;
      rd_req = 1'b1;
      narrow = 1'b0;
      rd_sel = 2'd2;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      reset = 1'b0;
      checks++;
      if (dout !== 32'h0 || dout_valid !== 1'b0 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_req: dout=%h valid=%b hold=%b, want 0/0/0", dout, dout_valid, hold_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_req_drop: valid=%b, want 0", dout_valid);
      end
   endtask
   task automatic test_no_timeout;
      a1_x = 16'h0010;
      a1_y = 16'h0020;
      req(1'b1, 1'b0, 2'd0);
      a1_y = 16'h0099;
      repeat (8) @(posedge clk);
      #1;
`ifdef ADDR_RDBK_TIMEOUT_EN
      checks++;
      if (hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL long_hold: hold=%b, want 0", hold_valid);
      end
`else
      checks++;
      if (hold_valid !== 1'b1) begin
         errors++;
         $display("FAIL long_hold: hold=%b, want 1", hold_valid);
      end
      req(1'b1, 1'b1, 2'd0);
      checks++;
      if (dout !== 32'h00000020 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL long_hold_hi: dout=%h hold=%b, want 00000020/0", dout, hold_valid);
      end
`endif
   endtask
`ifdef ADDR_RDBK_TIMEOUT_EN
   task automatic test_timeout;
      a1_y = 16'h0020;
      req(1'b1, 1'b0, 2'd0);
      a1_y = 16'h0099;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL to_drop: hold=%b, want 0", hold_valid);
      end
      req(1'b1, 1'b1, 2'd0);
      checks++;
      if (dout !== 32'h00000099) begin
         errors++;
         $display("FAIL to_live: dout=%h, want 00000099", dout);
      end
      a1_y = 16'h0020;
      req(1'b1, 1'b0, 2'd0);
      a1_y = 16'h0099;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (hold_valid !== 1'b1) begin
         errors++;
         $display("FAIL to_edge_hold: hold=%b, want 1", hold_valid);
      end
      req(1'b1, 1'b1, 2'd0);
      checks++;
      if (dout !== 32'h00000020 || hold_valid !== 1'b0) begin
         errors++;
         $display("FAIL to_edge_hi: dout=%h hold=%b, want 00000020/0", dout, hold_valid);
      end
   endtask
`endif
   initial begin
      test_reset;
      test_wide;
      test_narrow_pair;
      test_stale_tag;
      test_hi_idle;
      test_back_to_back;
      test_sel3_narrow;
      test_reset_in_req;
      test_no_timeout;
`ifdef ADDR_RDBK_TIMEOUT_EN
      test_timeout;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/addr_readback.md
Name: addr_readback

Overview:
- Return path for the blitter address unit: lets the GPU or CPU read back the live A1/A2 x/y address halves over the 32-bit data bus.
- Joins a selected x/y 16-bit pair into one 32-bit word: x on bits [0:15], y on bits [16:31].
- The output is registered and has a valid strobe.
- For 16-bit CPU accesses, a low-word read snapshots the whole pair, so the following high-word read returns a value from the same instant.

Parameters:
- HOLD_TIMEOUT, 255: cycles a narrow-read snapshot stays valid. Used only when ADDR_RDBK_TIMEOUT_EN is defined. Range 1..65535.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- rd_req in 1: single-cycle read request. Accepted every cycle; there is no back-pressure.
- rd_sel in [0:1]: source select. 0 = A1 pixel, 1 = A1 fraction, 2 = A2 pixel, 3 = reserved (reads return 0).
- narrow in 1: 1 = 16-bit CPU access, 0 = 32-bit GPU access.
- hiword in 1: for narrow accesses only, 1 = return the y half, 0 = return the x half. Ignored when narrow = 0.
- a1_x, a1_y in [0:15]: A1 pixel pointer halves.
- a1_fx, a1_fy in [0:15]: A1 fraction halves.
- a2_x, a2_y in [0:15]: A2 pixel pointer halves.
- dout out [0:31]: read data.
- dout_valid out 1: read data valid.
- hold_valid out 1: a narrow snapshot is pending.

Behaviour:
- Reset (sync, active-high): dout = 0, dout_valid = 0, hold_valid = 0, hold register = 0, state = IDLE, timeout counter = 0.
- Latency: a request sampled at edge N produces dout/dout_valid from edge N+1 for exactly one cycle. Back-to-back requests give back-to-back valid cycles.
- Source values are sampled in the request cycle. A concurrent update of the address registers, e.g. an ADDQ or a GPU write, is not visible in this read.
- Wide read (narrow = 0):
  - dout[0:15] = sel_x, dout[16:31] = sel_y.
  - Clears hold_valid and moves to IDLE.
- Narrow low read (narrow = 1, hiword = 0):
  - dout[0:15] = sel_x, dout[16:31] = 0.
  - Loads the hold register with sel_x/sel_y and the rd_sel tag; sets hold_valid; moves to HELD.
- Narrow high read (narrow = 1, hiword = 1):
  - In HELD with a matching rd_sel tag: dout[0:15] = 0, dout[16:31] = held y. Clears hold_valid and moves to IDLE.
  - Otherwise (IDLE, or tag mismatch): returns live sel_y in the same lane. hold_valid is cleared on a tag mismatch.
- States:
  - IDLE → HELD on a narrow low read.
  - HELD → HELD on another narrow low read; the hold register is reloaded from the new request.
  - HELD → IDLE on a wide read, a narrow high read, or a timeout.
  - Any state → IDLE on reset, including a reset in the same cycle as a request; that request is dropped and no dout_valid follows.
- rd_sel = 3: data is 0 but dout_valid still pulses. The hold register is updated as for any other select.
- No request: dout_valid = 0 and dout holds its last value.

Optional Feature:
- Macro: ADDR_RDBK_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to HELD and increments each cycle in HELD.
  - When it reaches HELD_TIMEOUT, hold_valid clears and the state moves to IDLE at the next edge.
  - A high read arriving in the same cycle as the timeout still uses the held value.
- Undefined: no counter; the snapshot persists until consumed or replaced.

Test Plan:
- Wide read: rd_sel=2, a2_x=0x1234, a2_y=0xABCD → next cycle dout=0x1234ABCD, dout_valid=1 for 1 cycle.
- Coherent narrow pair:
  - Low read of sel 0 with a1_x=0x0010, a1_y=0x0020 → dout[0:15]=0x0010, hold_valid=1.
  - Change a1_y to 0x0099, then do a high read → dout[16:31]=0x0020, hold_valid=0.
- Stale tag: low read of sel 0, then high read of sel 2 with a2_y=0x0777 → dout[16:31]=0x0777, hold_valid=0.
- Back-to-back wide reads of sels 0, 1, 3 on consecutive cycles → three consecutive valid words; the third is 0x00000000.
- Reset in the request cycle → no dout_valid; dout=0; hold_valid=0.
- With ADDR_RDBK_TIMEOUT_EN and HOLD_TIMEOUT=4: low read, idle 5 cycles, then high read → returns live y and hold_valid has already dropped. A high read on exactly the timeout cycle returns the held y.
